rcpu_irq_ctrl: RTL and testbench
================================

// Module: rcpu_irq_ctrl
// PURPOSE
//  Parametrised multi-channel interrupt controller driving the RCPU irq / turnOffIRQ /
//  intAddr / intData interface. Collects NCH device requests (per-channel edge or level),
//  masks them, selects one by fixed or round-robin priority, and presents a vectored
//  request to the CPU. Holds it until acknowledged. Config port sits on the MMIO decoder.
// PARAMETERS
//  NCH       8             number of request channels (1..16)
//  N         32            interrupt address width
//  M         16            data / config width
//  EDGE_MASK 8'hFF         bit i=1: channel i edge-triggered (rising), 0: level-high
//  RR        0             0: fixed priority (ch0 highest), 1: round-robin
//  VEC_STRIDE 4            address step between channel vectors
//  VEC_RESET 32'h0000_0100 reset value of vector base
//  HOLDOFF   2             cycles idle after ack before next arbitration (>=1)
// PORTS
//  clk        in  1     clock
//  rst        in  1     synchronous reset, active-high
//  irqIn      in  NCH   device requests, synchronous to clk
//  irq        out 1     request to CPU
//  turnOffIRQ in  1     CPU acknowledge (1-cycle pulse)
//  intAddr    out N     vector of granted channel
//  intData    out M     granted channel index, zero-extended
//  cfgWE      in  1     config write strobe
//  cfgAddr    in  2     0 mask, 1 pending (W1C), 2 vecBase[15:0], 3 vecBase[31:16]
//  cfgWData   in  M     config write data
//  cfgRData   out M     config read data, combinational from cfgAddr
// BEHAVIOUR
//  Reset: irq=0, intAddr=0, intData=0, mask=0, pending=0, prev=0, vecBase=VEC_RESET,
//   rrPtr=0, state=IDLE; rst overrides everything incl. an outstanding request.
//  Edge ch: pending[i] set at clk where irqIn[i]&~prev[i]; prev<=irqIn every cycle.
//  Level ch: effective request = irqIn[i] live; pending bit unused (reads 0).
//  eligible = mask & (edgePending | levelLive).
//  States: IDLE -> ASSERT when eligible!=0: latch ch, irq<=1,
//   intAddr<=vecBase+ch*VEC_STRIDE (mod 2^N), intData<=ch.
//  ASSERT: hold irq/intAddr/intData stable; mask/pending changes do not withdraw it.
//   On turnOffIRQ: irq<=0, clear pending[ch] (edge ch), rrPtr<=ch+1 mod NCH, -> HOLD.
//  HOLD: count HOLDOFF cycles, then IDLE. turnOffIRQ outside ASSERT ignored.
//  Latency: irqIn rising sampled at edge k -> pending at k -> irq=1 after edge k+1.
//   Ack at edge j -> irq=0 after j; next irq earliest after j+HOLDOFF+1.
//  Priority: RR=0 lowest index wins; RR=1 first eligible at/after rrPtr, wrapping.
//  Simultaneous: new rising edge on ch in ack cycle -> pending stays set (set wins);
//   cfg W1C and edge same cycle same bit -> set wins; cfg write and ack same cycle both
//   take effect. vecBase write during ASSERT affects next grant only.
//  intAddr/intData keep last value after ack (not cleared).
//  cfgRData: 0 {0,mask}, 1 {0,pending}, 2 vecBase low, 3 vecBase high; bits >=NCH read 0.
// STRUCTURE
//  State encodings (IDLE/ASSERT/HOLD) and CFG_* addresses go in shared "constants".
//  Sub-module irq_prio_arbiter: combinational find-first over NCH with rotating start
//   (start=0 when RR=0); outputs valid + index. Rest is register/FSM logic in top.
// TESTING
//  1 Reset, mask=8'h01, pulse irqIn[0] 1 cycle -> irq=1 two clocks later,
//    intAddr=32'h100, intData=0; ack -> irq=0 next clock, pending=0.
//  2 RR=0, mask=FF, ch5 and ch2 edges same cycle -> grant ch2 (intAddr=0x108);
//    ack, after HOLDOFF -> grant ch5 (0x114).
//  3 RR=1, ch1 and ch3 levels held high -> grants alternate 1,3,1,3 across acks.
//  4 Edge on ch0 in same cycle as ack of ch0 -> pending[0] stays 1, irq re-asserts
//    after HOLDOFF; mask cleared in ASSERT -> irq held until ack.
//  5 vecBase=32'hFFFF_FFFC, ch1 granted -> intAddr=32'h0000_0000 (wrap).
//  6 Assert rst while irq=1 -> next clock irq=0, mask=0, pending=0, vecBase=0x100.

Source files
------------

// File: rtl/rcpu_irq_ctrl_pkg.sv
// rtl/rcpu_irq_ctrl_pkg.sv - shared constants for the RCPU interrupt controller
package rcpu_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } irqState_t;

    localparam logic [1:0] CFG_MASK    = 2'd0;
    localparam logic [1:0] CFG_PENDING = 2'd1;
    localparam logic [1:0] CFG_VEC_LO  = 2'd2;
    localparam logic [1:0] CFG_VEC_HI  = 2'd3;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcpu_irq_ctrl_prio_arbiter.sv
// rtl/rcpu_irq_ctrl_prio_arbiter.sv - find-first arbiter with a rotating start index
module irq_prio_arbiter
    import rcpu_irq_ctrl_pkg::*;
#(
    parameter int NCH = 8,
    parameter int IW  = idxWidth(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  start,
    output logic           valid,
    output logic [IW-1:0]  idx
);

    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(start) + k;
            if (j >= NCH) j = j - NCH;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rcpu_irq_ctrl.sv
// rtl/rcpu_irq_ctrl.sv - multi-channel vectored interrupt controller for the RCPU
module rcpu_irq_ctrl
    import rcpu_irq_ctrl_pkg::*;
#(
    parameter int          NCH        = 8,
    parameter int          N          = 32,
    parameter int          M          = 16,
    parameter logic [15:0] EDGE_MASK  = 16'h00FF,
    parameter bit          RR         = 1'b0,
    parameter int          VEC_STRIDE = 4,
    parameter logic [N-1:0] VEC_RESET = N'(32'h0000_0100),
    parameter int          HOLDOFF    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] irqIn,
    output logic           irq,
    input  logic           turnOffIRQ,
    output logic [N-1:0]   intAddr,
    output logic [M-1:0]   intData,
    input  logic           cfgWE,
    input  logic [1:0]     cfgAddr,
    input  logic [M-1:0]   cfgWData,
    output logic [M-1:0]   cfgRData
);

    localparam int IW = idxWidth(NCH);
    localparam logic [NCH-1:0] EDGE = EDGE_MASK[NCH-1:0];

    irqState_t      state;
    logic [NCH-1:0] mask, pending, prev, pendingNext, ackClr, w1cClr, eligible;
    logic [N-1:0]   vecBase;
    logic [IW-1:0]  rrPtr, grantCh, arbIdx;
    logic [7:0]     holdCnt;
    logic           arbValid, ackNow;

    assign ackNow   = (state == ST_ASSERT) && turnOffIRQ;
    assign eligible = mask & ((pending & EDGE) | (irqIn & ~EDGE));

    irq_prio_arbiter #(.NCH(NCH), .IW(IW)) uArb (
        .req   (eligible),
        .start (RR ? rrPtr : '0),
        .valid (arbValid),
        .idx   (arbIdx)
    );

    // New rising edges beat both the W1C clear and the ack clear in the same cycle.
    always_comb begin
        ackClr = '0;
        w1cClr = '0;
        if (ackNow) ackClr[grantCh] = 1'b1;
        if (cfgWE && cfgAddr == CFG_PENDING) w1cClr = cfgWData[NCH-1:0];
        pendingNext = ((pending & ~w1cClr & ~ackClr) | (irqIn & ~prev)) & EDGE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            intAddr <= '0;
            intData <= '0;
            mask    <= '0;
            pending <= '0;
            prev    <= '0;
            vecBase <= VEC_RESET;
            rrPtr   <= '0;
            grantCh <= '0;
            holdCnt <= '0;
        end else begin
            prev    <= irqIn;
            pending <= pendingNext;
            if (cfgWE) begin
                case (cfgAddr)
                    CFG_MASK:   mask           <= cfgWData[NCH-1:0];
                    CFG_VEC_LO: vecBase[15:0]  <= cfgWData[15:0];
                    CFG_VEC_HI: vecBase[31:16] <= cfgWData[15:0];
                    default: ;
                endcase
            end
            case (state)
                ST_IDLE: begin
                    if (arbValid) begin
                        state   <= ST_ASSERT;
                        irq     <= 1'b1;
                        grantCh <= arbIdx;
                        intAddr <= vecBase + N'(arbIdx) * N'(VEC_STRIDE);
                        intData <= M'(arbIdx);
                    end
                end
                ST_ASSERT: begin
                    if (turnOffIRQ) begin
                        irq     <= 1'b0;
                        rrPtr   <= (int'(grantCh) == NCH - 1) ? '0 : IW'(grantCh + 1'b1);
                        holdCnt <= 8'(HOLDOFF - 1);
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (holdCnt == 8'd0) state <= ST_IDLE;
                    else holdCnt <= holdCnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (cfgAddr)
            CFG_MASK:    cfgRData = M'(mask);
            CFG_PENDING: cfgRData = M'(pending);
            CFG_VEC_LO:  cfgRData = M'(vecBase[15:0]);
            default:     cfgRData = M'(vecBase[31:16]);
        endcase
    end

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// tb/tb_rcpu_irq_ctrl.sv - self-checking bench for rcpu_irq_ctrl (fixed and round-robin)
module tb_rcpu_irq_ctrl;

    localparam int HOLDOFF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  irqInF = '0, irqInR = '0;
    logic        ackF = 1'b0, ackR = 1'b0;
    logic        weF = 1'b0, weR = 1'b0;
    logic [1:0]  addrF = '0, addrR = '0;
    logic [15:0] wdataF = '0, wdataR = '0;
    logic        irqF, irqR;
    logic [31:0] intAddrF, intAddrR;
    logic [15:0] intDataF, intDataR, rdF, rdR;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    rcpu_irq_ctrl #(.RR(1'b0), .EDGE_MASK(16'h00FF), .HOLDOFF(HOLDOFF)) dutF (
        .clk(clk), .rst(rst), .irqIn(irqInF), .irq(irqF), .turnOffIRQ(ackF),
        .intAddr(intAddrF), .intData(intDataF), .cfgWE(weF), .cfgAddr(addrF),
        .cfgWData(wdataF), .cfgRData(rdF)
    );

    rcpu_irq_ctrl #(.RR(1'b1), .EDGE_MASK(16'h00F5), .HOLDOFF(HOLDOFF)) dutR (
        .clk(clk), .rst(rst), .irqIn(irqInR), .irq(irqR), .turnOffIRQ(ackR),
        .intAddr(intAddrR), .intData(intDataR), .cfgWE(weR), .cfgAddr(addrR),
        .cfgWData(wdataR), .cfgRData(rdR)
    );

    typedef struct {
        logic [7:0]  pend;
        logic [7:0]  prev;
        logic [7:0]  mask;
        logic [31:0] vb;
        bit          busy;
        int          holdLeft;
        int          ch;
        int          nextStart;
        logic        irq;
        logic [31:0] addr;
        logic [15:0] data;
    } mdl_t;

    mdl_t mF, mR;

    // Reference: which channel wins, when, and what the CPU sees, from the rules directly.
    function automatic mdl_t mStep(input mdl_t s, input bit rr, input logic [7:0] edg,
                                   input logic [7:0] in, input logic ack, input logic we,
                                   input logic [1:0] a, input logic [15:0] wd, input logic r);
        mdl_t n;
        bit   req [8];
        bit   acked;
        n = s;
        if (r) begin
            n.pend = 0; n.prev = 0; n.mask = 0; n.vb = 32'h100; n.busy = 0;
            n.holdLeft = 0; n.ch = 0; n.nextStart = 0; n.irq = 0; n.addr = 0; n.data = 0;
            return n;
        end
        acked = s.busy && s.irq && ack;
        for (int i = 0; i < 8; i++) begin
            req[i] = s.mask[i] && (edg[i] ? s.pend[i] : in[i]);
            if (edg[i]) begin
                n.pend[i] = (in[i] && !s.prev[i]) ||
                            (s.pend[i] && !(we && a == 2'd1 && wd[i]) && !(acked && s.ch == i));
            end else begin
                n.pend[i] = 1'b0;
            end
        end
        n.prev = in;
        if (we && a == 2'd0) n.mask = wd[7:0];
        if (we && a == 2'd2) n.vb = {s.vb[31:16], wd};
        if (we && a == 2'd3) n.vb = {wd, s.vb[15:0]};
        if (!s.busy && s.holdLeft == 0) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = ((rr ? s.nextStart : 0) + k) % 8;
                if (!n.busy && req[c]) begin
                    n.busy = 1; n.irq = 1; n.ch = c;
                    n.addr = s.vb + 32'(c * 4);
                    n.data = 16'(c);
                end
            end
        end else if (acked) begin
            n.busy = 0; n.irq = 0;
            n.nextStart = (s.ch + 1) % 8;
            n.holdLeft = HOLDOFF;
        end else if (!s.busy) begin
            n.holdLeft = s.holdLeft - 1;
        end
        return n;
    endfunction

    function automatic logic [15:0] mRead(input mdl_t s, input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, s.mask};
            2'd1:    return {8'h00, s.pend};
            2'd2:    return s.vb[15:0];
            default: return s.vb[31:16];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        mF = mStep(mF, 1'b0, 8'hFF, irqInF, ackF, weF, addrF, wdataF, rst);
        mR = mStep(mR, 1'b1, 8'hF5, irqInR, ackR, weR, addrR, wdataR, rst);
        #1;
        chk("F.irq", 32'(irqF), 32'(mF.irq));
        chk("F.intAddr", intAddrF, mF.addr);
        chk("F.intData", 32'(intDataF), 32'(mF.data));
        chk("F.cfgRData", 32'(rdF), 32'(mRead(mF, addrF)));
        chk("R.irq", 32'(irqR), 32'(mR.irq));
        chk("R.intAddr", intAddrR, mR.addr);
        chk("R.intData", 32'(intDataR), 32'(mR.data));
        chk("R.cfgRData", 32'(rdR), 32'(mRead(mR, addrR)));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfgF(input logic [1:0] a, input logic [15:0] d);
        weF = 1'b1; addrF = a; wdataF = d;
        step();
        weF = 1'b0;
    endtask

    int expCh [4] = '{1, 3, 1, 3};

    initial begin
        // 1: reset state and single edge request
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset.irq", 32'(irqF), 0);
        chk("reset.intAddr", intAddrF, 0);
        chk("reset.mask", 32'(rdF), 0);
        cfgF(2'd0, 16'h0001);
        irqInF = 8'h01; step();
        irqInF = 8'h00; step();
        chk("t1.irq", 32'(irqF), 1);
        chk("t1.intAddr", intAddrF, 32'h100);
        chk("t1.intData", 32'(intDataF), 0);
        ackF = 1'b1; addrF = 2'd1; step();
        ackF = 1'b0;
        chk("t1.ackIrq", 32'(irqF), 0);
        chk("t1.pending", 32'(rdF), 0);
        cyc(3);

        // 2: fixed priority, then next grant after holdoff
        cfgF(2'd0, 16'h00FF);
        irqInF = 8'h24; step();
        irqInF = 8'h00; step();
        chk("t2.intAddr", intAddrF, 32'h108);
        chk("t2.intData", 32'(intDataF), 2);
        ackF = 1'b1; step();
        ackF = 1'b0;
        step(); step();
        chk("t2.holdIrq", 32'(irqF), 0);
        chk("t2.keepAddr", intAddrF, 32'h108);
        step();
        chk("t2.irq2", 32'(irqF), 1);
        chk("t2.intAddr2", intAddrF, 32'h114);
        ackF = 1'b1; step();
        ackF = 1'b0;
        cyc(3);

        // 3: round-robin between two held level channels
        weR = 1'b1; addrR = 2'd0; wdataR = 16'h00FF; step();
        weR = 1'b0;
        irqInR = 8'h0A;
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < 10 && !irqR; w++) step();
            chk("t3.irq", 32'(irqR), 1);
            chk("t3.grant", 32'(intDataR), 32'(expCh[g]));
            ackR = 1'b1; step();
            ackR = 1'b0;
        end
        irqInR = 8'h00;
        cyc(3);

        // 4: edge in the ack cycle survives; mask clear cannot withdraw irq
        cfgF(2'd0, 16'h0001);
        irqInF = 8'h01; step();
        irqInF = 8'h00; step();
        chk("t4.irq", 32'(irqF), 1);
        irqInF = 8'h01; ackF = 1'b1; addrF = 2'd1; step();
        irqInF = 8'h00; ackF = 1'b0;
        chk("t4.pendingKept", 32'(rdF), 1);
        step(); step();
        chk("t4.holdIrq", 32'(irqF), 0);
        step();
        chk("t4.reassert", 32'(irqF), 1);
        cfgF(2'd0, 16'h0000);
        chk("t4.maskedHeld", 32'(irqF), 1);
        ackF = 1'b1; step();
        ackF = 1'b0;
        chk("t4.ack", 32'(irqF), 0);
        cyc(4);

        // 5: vector address wraps modulo 2^32
        cfgF(2'd2, 16'hFFFC);
        cfgF(2'd3, 16'hFFFF);
        cfgF(2'd0, 16'h0002);
        irqInF = 8'h02; step();
        irqInF = 8'h00; step();
        chk("t5.irq", 32'(irqF), 1);
        chk("t5.wrapAddr", intAddrF, 32'h0000_0000);
        chk("t5.intData", 32'(intDataF), 1);

        // 6: reset while a request is outstanding
        rst = 1'b1; addrF = 2'd0; step();
        rst = 1'b0;
        chk("t6.irq", 32'(irqF), 0);
        chk("t6.mask", 32'(rdF), 0);
        addrF = 2'd1; #1;
        chk("t6.pending", 32'(rdF), 0);
        addrF = 2'd2; #1;
        chk("t6.vecLo", 32'(rdF), 32'h0100);
        addrF = 2'd3; #1;
        chk("t6.vecHi", 32'(rdF), 0);
        cyc(2);

        // Random traffic against the reference
        for (int c = 0; c < 600; c++) begin
            irqInF = 8'($urandom) & 8'($urandom);
            irqInR = 8'($urandom) & 8'($urandom);
            ackF   = irqF ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            ackR   = irqR ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            weF    = ($urandom_range(0, 7) == 0);
            weR    = ($urandom_range(0, 7) == 0);
            addrF  = 2'($urandom);
            addrR  = 2'($urandom);
            wdataF = 16'($urandom);
            wdataR = 16'($urandom);
            rst    = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0; weF = 1'b0; weR = 1'b0; ackF = 1'b0; ackR = 1'b0;
        irqInF = '0; irqInR = '0;
        step();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
